// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU MEM-stage, auxiliary requester and memory-side signals
// handled by dmem_port_arbiter.
//   slave  : the arbiter's view (requests in, memory port and status out)
//   master : the surrounding system's view (pipeline, aux agent, memory)
// Signal groups:
//   cpu_*      MEM-stage load/store request, load data and pipeline stall
//   aux_*      auxiliary (DMA/debug) request with one-cycle ready pulse
//   mem_*      shared variable-latency memory port
//   bus_err    sticky timeout flag, err_clr clears it
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_memrd;
   logic              cpu_memwr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              pipe_stall;

   logic              aux_valid;
   logic              aux_we;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_wdata;
   logic              aux_ready;
   logic [DATA_W-1:0] aux_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              bus_err;
   logic              err_clr;

   modport slave (
      input  cpu_memrd, cpu_memwr, cpu_addr, cpu_wdata,
      output cpu_rdata, pipe_stall,
      input  aux_valid, aux_we, aux_addr, aux_wdata,
      output aux_ready, aux_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output bus_err,
      input  err_clr
   );

   modport master (
      output cpu_memrd, cpu_memwr, cpu_addr, cpu_wdata,
      input  cpu_rdata, pipe_stall,
      output aux_valid, aux_we, aux_addr, aux_wdata,
      input  aux_ready, aux_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  bus_err,
      output err_clr
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one variable-latency data-memory port between the MEM stage and an
// auxiliary requester. One access is in flight at a time; the pipeline is
// stalled until its own access completes, a waiting aux requester is forced
// through after STARVE_LIMIT cycles, and accesses with no ack are aborted
// after TIMEOUT cycles (sticky bus_err).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    dmem_port_arbiter_if.slave (cpu_*, aux_*, mem_*, bus_err, err_clr)
//
// state  | meaning
// IDLE   | no access; arbitrate and latch the winner's fields
// C_BUSY | CPU access on the memory port, waiting for ack/timeout
// C_DONE | CPU data valid, pipeline released for one cycle
// A_BUSY | aux access on the memory port, waiting for ack/timeout
// A_DONE | aux_ready pulse, aux_rdata valid
module dmem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   dmem_port_arbiter_if.slave   bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] C_BUSY = 3'd1;
   localparam logic [2:0] C_DONE = 3'd2;
   localparam logic [2:0] A_BUSY = 3'd3;
   localparam logic [2:0] A_DONE = 3'd4;

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [2:0]        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
   logic              bus_err_q, bus_err_d;
   logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic [TC_W-1:0]   tmo_cnt_q, tmo_cnt_d;

   logic              cpu_req;
   logic              aux_win;
   logic              aux_grant;
   logic              err_set;
   logic [DATA_W-1:0] rd_val;

   assign cpu_req   = bus.cpu_memrd | bus.cpu_memwr;
   assign aux_win   = bus.aux_valid &
                      (~cpu_req | (starve_cnt_q == SC_W'(STARVE_LIMIT)));
   assign aux_grant = (state_q == IDLE) & aux_win;
   // Writes return zero so stale memory data never leaks to the requester.
   assign rd_val    = mem_we_q ? '0 : bus.mem_rdata;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      aux_rdata_d = aux_rdata_q;
      tmo_cnt_d   = tmo_cnt_q;
      err_set     = 1'b0;

      case (state_q)
         IDLE: begin
            if (aux_win) begin
               state_d     = A_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.aux_we;
               mem_addr_d  = bus.aux_addr;
               mem_wdata_d = bus.aux_wdata;
               tmo_cnt_d   = '0;
            end else if (cpu_req) begin
               state_d     = C_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.cpu_memwr;
               mem_addr_d  = bus.cpu_addr;
               mem_wdata_d = bus.cpu_wdata;
               tmo_cnt_d   = '0;
            end
         end
         C_BUSY, A_BUSY: begin
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               if (state_q == C_BUSY) begin
                  state_d     = C_DONE;
                  cpu_rdata_d = rd_val;
               end else begin
                  state_d     = A_DONE;
                  aux_rdata_d = rd_val;
               end
            end else if (tmo_cnt_q == TC_W'(TIMEOUT - 1)) begin
               mem_req_d = 1'b0;
               err_set   = 1'b1;
               if (state_q == C_BUSY) begin
                  state_d     = C_DONE;
                  cpu_rdata_d = '0;
               end else begin
                  state_d     = A_DONE;
                  aux_rdata_d = '0;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TC_W'(1);
            end
         end
         C_DONE, A_DONE: state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (aux_grant || !bus.aux_valid) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + SC_W'(1);
      end
   end

   // A timeout in the same cycle as err_clr keeps the flag set.
   assign bus_err_d = err_set | (bus_err_q & ~bus.err_clr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         aux_rdata_q  <= '0;
         bus_err_q    <= 1'b0;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         aux_rdata_q  <= aux_rdata_d;
         bus_err_q    <= bus_err_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.aux_rdata  = aux_rdata_q;
   assign bus.aux_ready  = (state_q == A_DONE);
   assign bus.bus_err    = bus_err_q;
   assign bus.pipe_stall = cpu_req & (state_q != C_DONE);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by a randomized
// run scored against a transaction-level model (word memory, aux wait age).
module tb_dmem_port_arbiter;
   localparam int STARVE_LIMIT = 8;
   localparam int TIMEOUT      = 255;

   logic clk;
   logic reset;

   dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mem_model [16];
   bit          resp_en   = 1'b0;
   bit          resp_rand = 1'b0;
   int          resp_lat  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: acks after a fixed or random number of wait cycles.
   initial begin : responder
      int wcnt;
      int cur_lat;
      wcnt          = 0;
      cur_lat       = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (resp_en && bus.mem_req) begin
            if (wcnt >= cur_lat) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = bus.mem_we ? $urandom : mem_model[bus.mem_addr[3:0]];
               if (bus.mem_we) mem_model[bus.mem_addr[3:0]] = bus.mem_wdata;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt    = 0;
            cur_lat = resp_rand ? int'($urandom_range(0, 4)) : resp_lat;
         end
      end
   end

   task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             output int stalls, output logic [31:0] rd,
                             output logic [31:0] m_we, output logic [31:0] m_addr,
                             output logic [31:0] m_wd);
      bit seen;
      seen   = 1'b0;
      stalls = 0;
      m_we   = '1;
      m_addr = '1;
      m_wd   = '1;
      bus.cpu_memwr = wr;
      bus.cpu_memrd = !wr;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.mem_req && !seen) begin
            seen   = 1'b1;
            m_we   = 32'(bus.mem_we);
            m_addr = bus.mem_addr;
            m_wd   = bus.mem_wdata;
         end
         if (!bus.pipe_stall) break;
         stalls++;
      end
      rd = bus.cpu_rdata;
      @(posedge clk); #1;
      bus.cpu_memrd = 1'b0;
      bus.cpu_memwr = 1'b0;
   endtask

   task automatic wait_aux(output bit ok, output logic [31:0] rd, output logic [31:0] m_addr);
      bit seen;
      seen   = 1'b0;
      ok     = 1'b0;
      rd     = '1;
      m_addr = '1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.mem_req && !seen) begin
            seen   = 1'b1;
            m_addr = bus.mem_addr;
         end
         if (bus.aux_ready) begin
            ok = 1'b1;
            rd = bus.aux_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      bus.aux_valid = 1'b0;
   endtask

   initial begin : main
      int          stalls;
      logic [31:0] rd, m_we, m_addr, m_wd;
      bit          ok;
      bit          own [4];
      int          ng, pulses, pulses_at_g3;
      bit          prev_req;
      // randomized-phase model state
      bit          cpu_pend, cpu_wr, cpu_done, aux_pend, aux_w, aux_done;
      logic [31:0] cpu_a, cpu_wd, aux_a, aux_wd;
      bit          s_cpu_pend, s_cpu_wr, s_aux_pend, s_aux_w;
      logic [31:0] s_cpu_a, s_cpu_wd, s_aux_a, s_aux_wd;
      int          aux_wait, cpu_age, aux_age;
      bit          exp_aux;

      for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
      mem_model[0] = 32'h1234;
      mem_model[7] = 32'h7777;

      reset         = 1'b0;
      bus.cpu_memrd = 1'b0;
      bus.cpu_memwr = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.aux_valid = 1'b0;
      bus.aux_we    = 1'b0;
      bus.aux_addr  = '0;
      bus.aux_wdata = '0;
      bus.err_clr   = 1'b0;
      resp_en       = 1'b1;
      resp_lat      = 1;
      repeat (3) @(negedge clk);
      check_val("rst_mem_req", 32'(bus.mem_req), 0);
      check_val("rst_stall", 32'(bus.pipe_stall), 0);
      check_val("rst_aux_ready", 32'(bus.aux_ready), 0);
      check_val("rst_bus_err", 32'(bus.bus_err), 0);
      check_val("rst_mem_addr", bus.mem_addr, 0);
      check_val("rst_cpu_rdata", bus.cpu_rdata, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // CPU load, ack on the second request cycle
      cpu_access(1'b0, 32'h10, 32'h0, stalls, rd, m_we, m_addr, m_wd);
      check_val("ld_stalls", 32'(stalls), 3);
      check_val("ld_rdata", rd, 32'h1234);
      check_val("ld_mem_addr", m_addr, 32'h10);
      check_val("ld_mem_we", m_we, 0);

      // CPU store, ack on the first request cycle
      resp_lat = 0;
      cpu_access(1'b1, 32'h20, 32'hCAFE, stalls, rd, m_we, m_addr, m_wd);
      check_val("st_stalls", 32'(stalls), 2);
      check_val("st_mem_we", m_we, 1);
      check_val("st_mem_addr", m_addr, 32'h20);
      check_val("st_mem_wdata", m_wd, 32'hCAFE);
      check_val("st_rdata", rd, 0);
      check_val("st_mem_written", mem_model[0], 32'hCAFE);

      // Simultaneous requests with no aux history: CPU first, then aux
      resp_lat      = 1;
      bus.aux_valid = 1'b1;
      bus.aux_we    = 1'b0;
      bus.aux_addr  = 32'h5;
      cpu_access(1'b0, 32'h3, 32'h0, stalls, rd, m_we, m_addr, m_wd);
      check_val("tie_cpu_first", m_addr, 32'h3);
      check_val("tie_cpu_rdata", rd, mem_model[3]);
      wait_aux(ok, rd, m_addr);
      check_val("tie_aux_done", 32'(ok), 1);
      check_val("tie_aux_addr", m_addr, 32'h5);
      check_val("tie_aux_rdata", rd, mem_model[5]);

      // Continuous CPU loads with continuous aux: aux forced in on grant #3
      bus.cpu_memrd = 1'b1;
      bus.cpu_addr  = 32'h7;
      bus.aux_valid = 1'b1;
      bus.aux_we    = 1'b0;
      bus.aux_addr  = 32'h9;
      ng = 0; pulses = 0; pulses_at_g3 = -1; prev_req = bus.mem_req;
      for (int c = 0; c < 80 && ng < 4; c++) begin
         @(negedge clk);
         if (bus.aux_ready) pulses++;
         if (bus.mem_req && !prev_req) begin
            own[ng] = (bus.mem_addr == 32'h9);
            if (ng == 3) pulses_at_g3 = pulses;
            ng++;
         end
         prev_req = bus.mem_req;
      end
      check_val("stv_grants", 32'(ng), 4);
      check_val("stv_g0_cpu", 32'(own[0]), 0);
      check_val("stv_g1_cpu", 32'(own[1]), 0);
      check_val("stv_g2_aux", 32'(own[2]), 1);
      check_val("stv_g3_cpu", 32'(own[3]), 0);
      check_val("stv_aux_ready", 32'(pulses_at_g3), 1);
      @(posedge clk); #1;
      bus.cpu_memrd = 1'b0;
      bus.aux_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Hung access: no ack, abort after TIMEOUT request cycles
      resp_en = 1'b0;
      cpu_access(1'b0, 32'h1, 32'h0, stalls, rd, m_we, m_addr, m_wd);
      check_val("tmo_stalls", 32'(stalls), 32'(TIMEOUT + 1));
      check_val("tmo_rdata", rd, 0);
      check_val("tmo_mem_req", 32'(bus.mem_req), 0);
      check_val("tmo_bus_err", 32'(bus.bus_err), 1);
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      check_val("tmo_err_clr", 32'(bus.bus_err), 0);
      @(posedge clk); #1;

      // Reset during C_BUSY, reissue afterwards
      bus.cpu_memrd = 1'b1;
      bus.cpu_addr  = 32'h2;
      @(negedge clk);
      @(negedge clk);
      check_val("rbusy_req", 32'(bus.mem_req), 1);
      reset = 1'b0;
      #1;
      check_val("rbusy_req_drop", 32'(bus.mem_req), 0);
      check_val("rbusy_stall", 32'(bus.pipe_stall), 1);
      @(posedge clk); #1;
      resp_en  = 1'b1;
      resp_lat = 0;
      reset    = 1'b1;
      cpu_access(1'b0, 32'h2, 32'h0, stalls, rd, m_we, m_addr, m_wd);
      check_val("rbusy_reissue", m_addr, 32'h2);
      check_val("rbusy_stalls", 32'(stalls), 2);
      check_val("rbusy_rdata", rd, mem_model[2]);

      // Randomized traffic against the transaction model
      resp_rand = 1'b1;
      cpu_pend = 0; cpu_done = 0; aux_pend = 0; aux_done = 0;
      cpu_wr = 0; aux_w = 0; cpu_a = 0; cpu_wd = 0; aux_a = 0; aux_wd = 0;
      aux_wait = 0; cpu_age = 0; aux_age = 0;
      prev_req = bus.mem_req;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk);
         s_cpu_pend = cpu_pend; s_cpu_wr = cpu_wr; s_cpu_a = cpu_a; s_cpu_wd = cpu_wd;
         s_aux_pend = aux_pend; s_aux_w = aux_w; s_aux_a = aux_a; s_aux_wd = aux_wd;
         #1;
         if (cpu_done) begin cpu_pend = 0; cpu_done = 0; end
         if (aux_done) begin aux_pend = 0; aux_done = 0; end
         if (cyc < 1850) begin
            if (!cpu_pend && $urandom_range(0, 2) == 0) begin
               cpu_pend = 1; cpu_wr = $urandom_range(0, 1) == 1;
               cpu_a = $urandom_range(0, 15); cpu_wd = $urandom; cpu_age = 0;
            end
            if (!aux_pend && $urandom_range(0, 3) == 0) begin
               aux_pend = 1; aux_w = $urandom_range(0, 1) == 1;
               aux_a = $urandom_range(0, 15); aux_wd = $urandom; aux_age = 0;
            end
         end
         bus.cpu_memrd = cpu_pend & !cpu_wr;
         bus.cpu_memwr = cpu_pend & cpu_wr;
         bus.cpu_addr  = cpu_a;
         bus.cpu_wdata = cpu_wd;
         bus.aux_valid = aux_pend;
         bus.aux_we    = aux_w;
         bus.aux_addr  = aux_a;
         bus.aux_wdata = aux_wd;
         @(negedge clk);
         if (bus.mem_req && !prev_req) begin
            exp_aux = s_aux_pend && (!s_cpu_pend || aux_wait >= STARVE_LIMIT);
            if (exp_aux) begin
               check_val("rnd_aux_addr", bus.mem_addr, s_aux_a);
               check_val("rnd_aux_we", 32'(bus.mem_we), 32'(s_aux_w));
               if (s_aux_w) check_val("rnd_aux_wdata", bus.mem_wdata, s_aux_wd);
            end else begin
               check_val("rnd_cpu_pending", 32'(s_cpu_pend), 1);
               check_val("rnd_cpu_addr", bus.mem_addr, s_cpu_a);
               check_val("rnd_cpu_we", 32'(bus.mem_we), 32'(s_cpu_wr));
               if (s_cpu_wr) check_val("rnd_cpu_wdata", bus.mem_wdata, s_cpu_wd);
            end
            if (exp_aux) aux_wait = 0;
            else if (s_aux_pend) aux_wait = (aux_wait < STARVE_LIMIT) ? aux_wait + 1 : aux_wait;
            else aux_wait = 0;
         end else begin
            if (s_aux_pend) aux_wait = (aux_wait < STARVE_LIMIT) ? aux_wait + 1 : aux_wait;
            else aux_wait = 0;
         end
         prev_req = bus.mem_req;
         if (cpu_pend) cpu_age++;
         if (aux_pend) aux_age++;
         if (cpu_pend && !bus.pipe_stall) begin
            check_val("rnd_cpu_rdata", bus.cpu_rdata, cpu_wr ? 32'h0 : mem_model[cpu_a[3:0]]);
            check_val("rnd_cpu_latency_ok", 32'(cpu_age <= 40), 1);
            cpu_done = 1;
         end
         if (bus.aux_ready) begin
            check_val("rnd_aux_ready_req", 32'(aux_pend), 1);
            check_val("rnd_aux_rdata", bus.aux_rdata, aux_w ? 32'h0 : mem_model[aux_a[3:0]]);
            check_val("rnd_aux_latency_ok", 32'(aux_age <= 40), 1);
            aux_done = 1;
         end
      end
      check_val("rnd_cpu_drained", 32'(cpu_pend & !cpu_done), 0);
      check_val("rnd_aux_drained", 32'(aux_pend & !aux_done), 0);
      check_val("rnd_bus_err", 32'(bus.bus_err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
